alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal 8..64, power of two).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: in1  input  WIDTH  operand A.
REQ-007 Port: in2  input  WIDTH  operand B.
REQ-008 Port: alu_control  input  4  operation select.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: alu_result  output  WIDTH  registered result.
REQ-012 Port: zero_flag  output  1  high when alu_result == 0, registered with alu_result.
REQ-013 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 Encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed), 1001 SLTU, 1010 MUL (low WIDTH bits of product), 1100 DIVU, 1101 REMU; other codes SHALL yield result 0 with 1-cycle latency.
REQ-015 ADD/SUB/MUL SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-016 Shift amount SHALL be in2[log2(WIDTH)-1:0]; upper in2 bits ignored.
REQ-017 SLT/SLTU SHALL produce 1 or 0 zero-extended to WIDTH.
REQ-018 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-019 in_ready SHALL equal (state == IDLE); a request is accepted on a clock edge with in_valid && in_ready, capturing in1, in2, alu_control.
REQ-020 Single-cycle ops: IDLE -> DONE on accept; out_valid high in the cycle after the accept edge (latency 1).
REQ-021 MUL: IDLE -> MUL on accept; shift-add one multiplier bit per cycle for WIDTH cycles; MUL -> DONE; out_valid first high WIDTH+1 cycles after the accept edge.
REQ-022 DIVU/REMU: IDLE -> DIV; restoring division, one quotient bit per cycle for WIDTH cycles; DIV -> DONE; same latency as MUL.
REQ-023 Divide by zero SHALL complete with full latency: DIVU result all ones, REMU result = in1.
REQ-024 DONE SHALL hold alu_result, zero_flag, out_valid stable until out_valid && out_ready; then DONE -> IDLE and out_valid drops the following cycle.
REQ-025 in_ready SHALL be low in DONE; a new request is accepted no earlier than the cycle after the result handshake (no overlap).
REQ-026 Operand changes on in1/in2/alu_control after acceptance SHALL not affect an in-flight operation.
REQ-027 in_valid while busy SHALL be ignored without side effects.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, alu_result 0, zero_flag 0, out_valid 0, busy 0, and clear internal counters/operand registers.
REQ-029 Reset asserted mid-MUL/DIV or in DONE SHALL abort the operation; no result is delivered after release.
REQ-030 in_ready SHALL be 1 while in reset and after release.

Configuration
REQ-031 Macro ALU_MC_DIV_EN: when defined, DIVU/REMU and the DIV state are implemented per REQ-022/023.
REQ-032 When ALU_MC_DIV_EN is undefined, DIV state and divider datapath are absent; 1100/1101 behave as undefined codes (result 0, zero_flag 1, latency 1).

Verification (WIDTH=32)
REQ-033 Reset, then ADD 0x7FFFFFFF + 0x00000001 with out_ready=1 -> out_valid one cycle after accept, alu_result 0x80000000, zero_flag 0.
REQ-034 SUB 5 - 5, then SLT 0xFFFFFFFF vs 1 and SLTU same operands -> results 0 (zero_flag 1), 1, 0.
REQ-035 MUL 0x0001_0000 * 0x0001_0003 -> out_valid exactly 33 cycles after accept, alu_result 0x0003_0000; in_ready low throughout.
REQ-036 With ALU_MC_DIV_EN: DIVU 100/7 -> 14, REMU 100/7 -> 2, DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9, each 33 cycles; without macro DIVU 100/7 -> 0 after 1 cycle.
REQ-037 Complete an ADD with out_ready=0 for 5 cycles -> out_valid and alu_result stable all 5 cycles, no new accept; out_ready=1 -> IDLE next cycle.
REQ-038 Assert rst_n low 10 cycles into a MUL -> all outputs 0 immediately, in_ready 1, no out_valid after release.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: handshaked multi-cycle ALU.
// Single-cycle ops finish one cycle after acceptance; MUL uses a shift-add
// sequencer, and DIVU/REMU use a restoring divider.
// Each multi-cycle op retires one bit per cycle for WIDTH cycles.
// Optional feature macro: ALU_MC_DIV_EN enables DIVU/REMU and the DIV state.
// Without it, 1100/1101 behave as undefined codes.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef ALU_MC_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;   // multiplicand / dividend-quotient shift register
  logic [WIDTH-1:0] b_reg;   // multiplier / divisor
  logic [WIDTH-1:0] acc;     // product accumulator / partial remainder
  logic [SW-1:0]    cnt;
`ifdef ALU_MC_DIV_EN
  logic             is_rem;
`endif

  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] mul_next;
`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_q_next;
`endif

  // Combinational result for the one-cycle operations; unknown codes give 0.
  function automatic logic [WIDTH-1:0] simple_op(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [SW-1:0] sh;
    logic [WIDTH-1:0] r;
    sh = b[SW-1:0];
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_XOR:  r = a ^ b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Next-step values for the single-cycle result and the iterative datapaths.
  always_comb begin
    single_res = simple_op(alu_control, in1, in2);
    mul_next   = acc + ({WIDTH{b_reg[0]}} & a_reg);
`ifdef ALU_MC_DIV_EN
    rem_sh       = {acc, a_reg[WIDTH-1]};
    rem_ge       = (rem_sh >= {1'b0, b_reg});
    // The true difference is below the divisor, so WIDTH bits hold it exactly.
    div_rem_next = rem_ge ? (rem_sh[WIDTH-1:0] - b_reg) : rem_sh[WIDTH-1:0];
    div_q_next   = {a_reg[WIDTH-2:0], rem_ge};
`endif
  end

  // Control FSM, sequencer datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_reg      <= {WIDTH{1'b0}};
      b_reg      <= {WIDTH{1'b0}};
      acc        <= {WIDTH{1'b0}};
      cnt        <= {SW{1'b0}};
`ifdef ALU_MC_DIV_EN
      is_rem     <= 1'b0;
`endif
      alu_result <= {WIDTH{1'b0}};
      zero_flag  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in1;
            b_reg <= in2;
            acc   <= {WIDTH{1'b0}};
            cnt   <= {SW{1'b0}};
            case (alu_control)
              OP_MUL: state <= MUL;
`ifdef ALU_MC_DIV_EN
              OP_DIVU, OP_REMU: begin
                is_rem <= (alu_control == OP_REMU);
                state  <= DIV;
              end
`endif
              default: begin
                alu_result <= single_res;
                zero_flag  <= (single_res == {WIDTH{1'b0}});
                out_valid  <= 1'b1;
                state      <= DONE;
              end
            endcase
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          acc   <= mul_next;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + {{(SW-1){1'b0}}, 1'b1};
          if (cnt == LAST_STEP) begin
            alu_result <= mul_next;
            zero_flag  <= (mul_next == {WIDTH{1'b0}});
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            state <= MUL;
          end
        end
`ifdef ALU_MC_DIV_EN
        DIV: begin
          acc   <= div_rem_next;
          a_reg <= div_q_next;
          cnt   <= cnt + {{(SW-1){1'b0}}, 1'b1};
          if (cnt == LAST_STEP) begin
            alu_result <= is_rem ? div_rem_next : div_q_next;
            zero_flag  <= ((is_rem ? div_rem_next : div_q_next) == {WIDTH{1'b0}});
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            state <= DIV;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32.
// Define ALU_MC_DIV_EN for both the RTL and the bench to cover the divider.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [3:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_result;
  logic         zero_flag;
  logic         busy;

  int checks;
  int errors;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .zero_flag(zero_flag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and wait for its result.
  // Latency counts cycles from acceptance (1 = next cycle).
  // Completes the handshake when out_ready is 1.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] res,
                       output logic zf, output int lat, output logic rdy_low);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    in_valid = 1'b1; in1 = a; in2 = b; alu_control = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5678; alu_control = 4'b0011;
    lat = 1;
    rdy_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1; lat++;
    end
    res = alu_result;
    zf  = zero_flag;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_result !== 32'h0 ||
        zero_flag !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b ov=%b res=%h zf=%b busy=%b, required 1 0 0 0 0",
               in_ready, out_valid, alu_result, zero_flag, busy);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] r; logic z; int l; logic rl;
    do_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, r, z, l, rl);
    checks++;
    if (r !== 32'h8000_0000 || z !== 1'b0 || l !== 1) begin
      errors++;
      $display("FAIL add: res=%h zf=%b lat=%0d, required 80000000 0 1", r, z, l);
    end
  endtask

  task automatic test_sub_slt();
    logic [W-1:0] r; logic z; int l; logic rl;
    do_op(4'b0100, 32'd5, 32'd5, r, z, l, rl);
    checks++;
    if (r !== 32'h0 || z !== 1'b1 || l !== 1) begin
      errors++;
      $display("FAIL sub: res=%h zf=%b lat=%0d, required 0 1 1", r, z, l);
    end
    do_op(4'b1000, 32'hFFFF_FFFF, 32'd1, r, z, l, rl);
    checks++;
    if (r !== 32'd1 || z !== 1'b0) begin
      errors++;
      $display("FAIL slt: res=%h zf=%b, required 1 0", r, z);
    end
    do_op(4'b1001, 32'hFFFF_FFFF, 32'd1, r, z, l, rl);
    checks++;
    if (r !== 32'd0 || z !== 1'b1) begin
      errors++;
      $display("FAIL sltu: res=%h zf=%b, required 0 1", r, z);
    end
  endtask

  task automatic test_logic_shift();
    logic [3:0]   ops  [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0101, 4'b0110,
                               4'b0111, 4'b1011, 4'b1111};
    logic [W-1:0] va   [8] = '{32'hF0F0_00FF, 32'hF0F0_0000, 32'hFFFF_0000,
                               32'h0000_0001, 32'h8000_0000, 32'h8000_0000,
                               32'h1234_5678, 32'hFFFF_FFFF};
    logic [W-1:0] vb   [8] = '{32'h0FF0_0F0F, 32'h0000_000F, 32'h0F0F_0F0F,
                               32'h0000_0023, 32'hFFFF_FFE4, 32'h0000_0004,
                               32'h0000_0001, 32'h0000_0001};
    logic [W-1:0] vexp [8] = '{32'h00F0_000F, 32'hF0F0_000F, 32'hF0F0_0F0F,
                               32'h0000_0008, 32'h0800_0000, 32'hF800_0000,
                               32'h0000_0000, 32'h0000_0000};
    logic [W-1:0] r; logic z; int l; logic rl;
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], va[i], vb[i], r, z, l, rl);
      checks++;
      if (r !== vexp[i] || z !== (vexp[i] == 32'h0) || l !== 1) begin
        errors++;
        $display("FAIL op%b: res=%h zf=%b lat=%0d, required %h %b 1",
                 ops[i], r, z, l, vexp[i], (vexp[i] == 32'h0));
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] r; logic z; int l; logic rl;
    do_op(4'b1010, 32'h0001_0000, 32'h0001_0003, r, z, l, rl);
    checks++;
    if (r !== 32'h0003_0000 || z !== 1'b0 || l !== 33 || rl !== 1'b1) begin
      errors++;
      $display("FAIL mul: res=%h zf=%b lat=%0d rdy_low=%b, required 00030000 0 33 1",
               r, z, l, rl);
    end
    do_op(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, l, rl);
    checks++;
    if (r !== 32'h0000_0001 || l !== 33) begin
      errors++;
      $display("FAIL mul_wrap: res=%h lat=%0d, required 00000001 33", r, l);
    end
  endtask

  task automatic test_div();
    logic [3:0]   ops  [4] = '{4'b1100, 4'b1101, 4'b1100, 4'b1101};
    logic [W-1:0] va   [4] = '{32'd100, 32'd100, 32'd9, 32'd9};
    logic [W-1:0] vb   [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
`ifdef ALU_MC_DIV_EN
    logic [W-1:0] vexp [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    int           elat = 33;
`else
    logic [W-1:0] vexp [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    int           elat = 1;
`endif
    logic [W-1:0] r; logic z; int l; logic rl;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], va[i], vb[i], r, z, l, rl);
      checks++;
      if (r !== vexp[i] || z !== (vexp[i] == 32'h0) || l !== elat) begin
        errors++;
        $display("FAIL div%0d: res=%h zf=%b lat=%0d, required %h %b %0d",
                 i, r, z, l, vexp[i], (vexp[i] == 32'h0), elat);
      end
    end
  endtask

  task automatic test_hold();
    logic ok;
    out_ready = 1'b0;
    in_valid = 1'b1; in1 = 32'd40; in2 = 32'd2; alu_control = 4'b0010;
    @(posedge clk); #1;
    // Keep requesting a different op while the result is held.
    in1 = 32'd1; in2 = 32'd1; alu_control = 4'b0100;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b1 || alu_result !== 32'd42 || zero_flag !== 1'b0 ||
          in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!ok || out_valid !== 1'b1 || alu_result !== 32'd42) begin
      errors++;
      $display("FAIL hold: ov=%b res=%h, required stable 1 0000002a", out_valid, alu_result);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release: ov=%b rdy=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_ghost: ov=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    in_valid = 1'b1; in1 = 32'd3; in2 = 32'd5; alu_control = 4'b1010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_result !== 32'h0 || zero_flag !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: ov=%b res=%h zf=%b busy=%b rdy=%b, required 0 0 0 0 1",
               out_valid, alu_result, zero_flag, busy, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy || !in_ready) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: activity seen=%b, required 0", seen);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; alu_control = 4'b0000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add();
    test_sub_slt();
    test_logic_shift();
    test_mul();
    test_div();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
